obstacle_field: RTL and testbench

OBSTACLE_FIELD -- requirements
Module: obstacle_field

---
 rtl/obstacle_field.sv | 176 +++++++++++++++++
 tb/tb_obstacle_field.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_field.sv
// obstacle_field: scrolling pipe-obstacle playfield for a side-scrolling game.
//
// The playfield is a ROWS x COLS bit array. Column 0 is the newest (right screen
// edge) and column COLS-1 the oldest. On every scroll tick each row shifts one
// column toward COLS-1 and a fresh column is injected at column 0. That column
// is either empty or a pipe with an open gap whose vertical position comes from
// an LFSR.
//
// Ports:
//   CLOCK_50      in   system clock, all state changes on its rising edge
//   resetn        in   synchronous active-low reset
//   enable        in   1 = divider runs and field scrolls, 0 = freeze
//   tick_out      out  registered one-cycle pulse per scroll tick
//   rd_valid      in   read request strobe
//   rd_row/rd_col in   read address
//   rd_data       out  registered cell value (0 when out of range)
//   rd_data_valid out  one cycle after each read request
//   hit_row/col   in   collision query, sampled every cycle
//   hit           out  registered collision result
//   spawn_count   out  pipes spawned, modulo 256
module obstacle_field #(
    parameter int unsigned ROWS         = 30,
    parameter int unsigned COLS         = 40,
    parameter int unsigned TICK_DIV     = 4161536,
    parameter int unsigned PIPE_SPACING = 10,
    parameter int unsigned GAP_ROWS     = 10,
    parameter int unsigned MARGIN       = 2,
    localparam int unsigned RW          = $clog2(ROWS + 1),
    localparam int unsigned CW          = $clog2(COLS)
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          enable,
    output logic          tick_out,
    input  logic          rd_valid,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic          rd_data,
    output logic          rd_data_valid,
    input  logic [RW-1:0] hit_row,
    input  logic [CW-1:0] hit_col,
    output logic          hit,
    output logic [7:0]    spawn_count
);

    localparam int unsigned DW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW    = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
    localparam int unsigned RANGE = ROWS - GAP_ROWS - 2 * MARGIN + 1;

    localparam logic [DW-1:0] DIV_LOAD   = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SPAWN_LOAD = SW'(PIPE_SPACING - 1);
    localparam logic [RW-1:0] ROWS_L     = RW'(ROWS);
    // One extra bit so a power-of-two COLS still compares correctly.
    localparam logic [CW:0]   COLS_L     = (CW + 1)'(COLS);
    localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

    // State
    logic [COLS-1:0] field_q [ROWS];
    logic [COLS-1:0] field_d [ROWS];
    logic [DW-1:0]   div_q, div_d;
    logic [SW-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [7:0]      spawn_count_q, spawn_count_d;
    logic            tick_out_q, tick_out_d;
    logic            rd_data_q, rd_data_d;
    logic            rd_data_valid_q, rd_data_valid_d;
    logic            hit_q, hit_d;

    // Combinational helpers
    logic            tick;
    logic            spawn;
    logic            lfsr_fb;
    int unsigned     gap_top;
    logic [ROWS-1:0] pipe_col;
    logic [ROWS-1:0] col_in;
    logic            rd_in_range;
    logic            rd_cell;
    logic            hit_cell;

    // Divider: tick fires in the enabled cycle where the counter sits at zero.
    always_comb begin
        tick  = enable && (div_q == '0);
        div_d = div_q;
        if (enable) begin
            div_d = tick ? DIV_LOAD : (div_q - DW'(1));
        end
    end

    // Spawn scheduling and pipe generation.
    always_comb begin
        spawn       = tick && (spawn_cnt_q == '0);
        spawn_cnt_d = spawn_cnt_q;
        if (tick) begin
            spawn_cnt_d = spawn ? SPAWN_LOAD : (spawn_cnt_q - SW'(1));
        end

        // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0 with feedback
        // entering at bit 15. The current value is used before it steps.
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = spawn ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;

        spawn_count_d = spawn_count_q + 8'(spawn);

        // Scale an 8-bit random value into [0, RANGE) without a divider.
        gap_top = MARGIN + ((32'(lfsr_q[7:0]) * RANGE) >> 8);
        for (int unsigned r = 0; r < ROWS; r++) begin
            pipe_col[r] = !((r >= gap_top) && (r < gap_top + GAP_ROWS));
        end
        col_in = spawn ? pipe_col : '0;
    end

    // Field shift: bit c of a row is column c, so a left shift moves toward COLS-1.
    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            field_d[r] = tick ? {field_q[r][COLS-2:0], col_in[r]} : field_q[r];
        end
    end

    // Read port and collision query both look at pre-shift contents.
    always_comb begin
        rd_in_range = (rd_row < ROWS_L) && ({1'b0, rd_col} < COLS_L);
        rd_cell     = 1'b0;
        if (rd_in_range) begin
            rd_cell = field_q[rd_row][rd_col];
        end
        rd_data_valid_d = rd_valid;
        rd_data_d       = rd_valid && rd_cell;

        // Rows past the field act as floor/ceiling; columns past it are open air.
        // The row check wins when both are out of range.
        hit_cell = 1'b0;
        if (hit_row >= ROWS_L) begin
            hit_cell = 1'b1;
        end else if ({1'b0, hit_col} < COLS_L) begin
            hit_cell = field_q[hit_row][hit_col];
        end
        hit_d = hit_cell;

        tick_out_d = tick;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                field_q[r] <= '0;
            end
            div_q           <= DIV_LOAD;
            spawn_cnt_q     <= '0;
            lfsr_q          <= LFSR_SEED;
            spawn_count_q   <= '0;
            tick_out_q      <= 1'b0;
            rd_data_q       <= 1'b0;
            rd_data_valid_q <= 1'b0;
            hit_q           <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                field_q[r] <= field_d[r];
            end
            div_q           <= div_d;
            spawn_cnt_q     <= spawn_cnt_d;
            lfsr_q          <= lfsr_d;
            spawn_count_q   <= spawn_count_d;
            tick_out_q      <= tick_out_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
            hit_q           <= hit_d;
        end
    end

    assign tick_out      = tick_out_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign hit           = hit_q;
    assign spawn_count   = spawn_count_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Randomized bench for obstacle_field (TICK_DIV=4). The driver computes each
// cycle's expected outputs from a behavioural model and queues them; the monitor
// pops one entry per clock and compares against the registered outputs.
module tb_obstacle_field;

    localparam int ROWS   = 30;
    localparam int COLS   = 40;
    localparam int TD     = 4;
    localparam int PS     = 10;
    localparam int GAP    = 10;
    localparam int MARGIN = 2;
    localparam int RW     = 5;
    localparam int CW     = 6;
    localparam int RANGE  = ROWS - GAP - 2 * MARGIN + 1;

    logic          CLOCK_50 = 1'b0;
    logic          resetn;
    logic          enable;
    logic          tick_out;
    logic          rd_valid;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic          rd_data;
    logic          rd_data_valid;
    logic [RW-1:0] hit_row;
    logic [CW-1:0] hit_col;
    logic          hit;
    logic [7:0]    spawn_count;

    always #5 CLOCK_50 = ~CLOCK_50;

    obstacle_field #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .TICK_DIV     (TD),
        .PIPE_SPACING (PS),
        .GAP_ROWS     (GAP),
        .MARGIN       (MARGIN)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .enable        (enable),
        .tick_out      (tick_out),
        .rd_valid      (rd_valid),
        .rd_row        (rd_row),
        .rd_col        (rd_col),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .hit_row       (hit_row),
        .hit_col       (hit_col),
        .hit           (hit),
        .spawn_count   (spawn_count)
    );

    typedef struct {
        bit rdv;
        bit rd;
        bit hit;
        bit tick;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model of the playfield.
    bit mf [ROWS][COLS];
    int en_cnt;
    int tick_idx;
    int nspawn;
    int lfsr;

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mf[r][c] = 1'b0;
        en_cnt   = 0;
        tick_idx = 0;
        nspawn   = 0;
        lfsr     = 16'hACE1;
    endtask

    task automatic model_tick();
        bit col [ROWS];
        int gt;
        int fb;
        for (int r = 0; r < ROWS; r++) col[r] = 1'b0;
        if (tick_idx % PS == 0) begin
            gt = MARGIN + ((lfsr & 255) * RANGE) / 256;
            for (int r = 0; r < ROWS; r++) col[r] = !(r >= gt && r < gt + GAP);
            fb   = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
            lfsr = (lfsr >> 1) | (fb << 15);
            nspawn++;
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = COLS - 1; c > 0; c--) mf[r][c] = mf[r][c-1];
            mf[r][0] = col[r];
        end
        tick_idx++;
    endtask

    // Drive one clock of stimulus and queue the outputs it should produce.
    task automatic step(input bit rst_n, input bit en, input bit rv,
                        input int rr, input int rc, input int hr, input int hc);
        exp_t e;
        bit   tk;
        resetn   = rst_n;
        enable   = en;
        rd_valid = rv;
        rd_row   = RW'(rr);
        rd_col   = CW'(rc);
        hit_row  = RW'(hr);
        hit_col  = CW'(hc);
        e.rdv = 1'b0; e.rd = 1'b0; e.hit = 1'b0; e.tick = 1'b0; e.cnt = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            tk    = en && ((en_cnt + 1) % TD == 0);
            e.rdv = rv;
            e.rd  = (rv && rr < ROWS && rc < COLS) ? mf[rr][rc] : 1'b0;
            if (hr >= ROWS)      e.hit = 1'b1;
            else if (hc >= COLS) e.hit = 1'b0;
            else                 e.hit = mf[hr][hc];
            if (en) en_cnt++;
            if (tk) model_tick();
            e.tick = tk;
            e.cnt  = nspawn % 256;
        end
        sb.push_back(e);
        @(negedge CLOCK_50);
    endtask

    task automatic rnd_step(input bit en);
        step(1'b1, en, ($urandom_range(0, 9) < 7), $urandom_range(0, 31), $urandom_range(0, 47),
             $urandom_range(0, 31), $urandom_range(0, 47));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_data_valid", 32'(rd_data_valid), 32'(e.rdv));
            if (e.rdv) chk("rd_data", 32'(rd_data), 32'(e.rd));
            chk("hit", 32'(hit), 32'(e.hit));
            chk("tick_out", 32'(tick_out), 32'(e.tick));
            chk("spawn_count", 32'(spawn_count), 32'(e.cnt));
        end
    end

    initial begin
        model_reset();
        // Two reset cycles, then free-run to the first tick.
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) rnd_step(1'b1);

        // Freeze and sweep column 0, with the directed collision queries alongside.
        for (int r = 0; r < ROWS; r++) begin
            int hr, hc;
            case (r % 4)
                0:       begin hr = 0;  hc = 0;  end
                1:       begin hr = 20; hc = 0;  end
                2:       begin hr = 30; hc = 5;  end
                default: begin hr = 3;  hc = 45; end
            endcase
            step(1'b1, 1'b0, 1'b1, r, 0, hr, hc);
        end

        // Scroll to the eleventh tick, then freeze and sweep columns 0..10.
        while (tick_idx < 11) rnd_step(1'b1);
        for (int c = 0; c <= 10; c++)
            for (int r = 0; r < ROWS; r++)
                step(1'b1, 1'b0, 1'b1, r, c, $urandom_range(0, 31), $urandom_range(0, 47));

        // Short scroll, a one-cycle reset mid-scroll, then a full frozen sweep.
        for (int i = 0; i < 6; i++) rnd_step(1'b1);
        step(1'b0, 1'b1, 1'b1, 1, 1, 1, 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                step(1'b1, 1'b0, 1'b1, r, c, r, c);

        // Random mix of enable, reads and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
            else rnd_step($urandom_range(0, 3) != 0);
        end

        // Run 256 spawns so spawn_count wraps, then a few more ticks.
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        while (nspawn < 256) rnd_step(1'b1);
        for (int i = 0; i < 20; i++) rnd_step(1'b1);

        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
